completion_unit: RTL and testbench
==================================

COMPLETION_UNIT -- requirements
Module: completion_unit

Interface
REQ-001 Parameter DATA_W, default 32, result data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 am_wb_valid / mem_wb_valid / mul_wb_valid  input  1 each  result presented by AluMisc / Mem / Mult unit.
REQ-006 am_wb_regdest / mem_wb_regdest / mul_wb_regdest  input  ADDR_W each  destination register.
REQ-007 am_wb_data / mem_wb_data / mul_wb_data  input  DATA_W each  result value.
REQ-008 am_wb_writereg / mem_wb_writereg / mul_wb_writereg  input  1 each  result writes the register file.
REQ-009 am_wb_ready / mem_wb_ready / mul_wb_ready  output  1 each  slot can accept this cycle.
REQ-010 wb_reg_addr  output  ADDR_W  register file write address.
REQ-011 wb_reg_data  output  DATA_W  register file write data.
REQ-012 wb_reg_write  output  1  register file write enable.
REQ-013 wb_sb_addr  output  ADDR_W  scoreboard entry to clear; equals wb_reg_addr.
REQ-014 wb_sb_clear  output  1  clear the pending bit in the scoreboard; asserted together with wb_reg_write.
REQ-015 cu_busy  output  1  at least one slot occupied.
REQ-016 cu_retired  output  16  count of retired results.

Function
REQ-017 The block SHALL hold one slot per unit, in index order am=0, mem=1, mul=2; each slot holds full, regdest, data and writereg.
REQ-018 A transfer SHALL occur on a rising edge where valid=1 and ready=1; the slot loads the inputs and sets full.
REQ-019 ready SHALL be 1 when the slot is empty or is granted in the same cycle. ready is combinational from slot state and grant, never from valid.
REQ-020 Each cycle, exactly one full slot SHALL be granted, chosen round-robin starting at index last_grant+1 mod 3.
REQ-021 last_grant SHALL update to the granted index on the edge of the grant; it holds when no slot is full.
REQ-022 On the grant edge, the granted slot SHALL clear full and the output registers SHALL load. The outputs are: wb_reg_addr=regdest, wb_reg_data=data, wb_reg_write=writereg AND (regdest!=0), and wb_sb_clear equal to wb_reg_write.
REQ-023 When no slot is granted, wb_reg_write and wb_sb_clear SHALL be 0 the next cycle; addr and data hold their last value.
REQ-024 A granted slot with writereg=0 (store) SHALL retire without a register or scoreboard write.
REQ-025 Latency: a result accepted at edge k SHALL appear on the outputs no earlier than the cycle after edge k+1. The worst case is 3 grant cycles when all slots are contending.
REQ-026 cu_retired SHALL increment by 1 on every grant edge, including writereg=0 and r0 cases, and wrap from 0xFFFF to 0.
REQ-027 Simultaneous accept and grant on the same slot SHALL leave the slot full with the new entry.
REQ-028 Slots for different units holding the same regdest SHALL retire in round-robin order with no merging. The issue stage guarantees no WAW hazard.
REQ-029 cu_busy SHALL be the OR of the three full flags, taken from registered state.

Reset
REQ-030 While reset=0, the block SHALL hold all slots empty and last_grant=2, so that am has first priority.
REQ-031 While reset=0, the block SHALL hold wb_reg_write=0, wb_sb_clear=0, wb_reg_addr=0, wb_reg_data=0, cu_retired=0 and cu_busy=0. All ready outputs are 1.
REQ-032 Reset asserted mid-operation SHALL discard all held results with no partial write.

Verification
REQ-033 Single result: mul_wb_valid for 1 cycle with regdest=7, data=0xDEADBEEF, writereg=1. Response: wb_reg_write=1, addr=7, data=0xDEADBEEF, wb_sb_clear=1 for exactly 1 cycle, 2 edges after acceptance; cu_retired=1.
REQ-034 All three units valid in the same cycle with regdest 1/2/3. Response: writes in order 1, 2, 3 on consecutive cycles. Then from last_grant=2 with am and mem both full, am wins first.
REQ-035 am held valid for 3 cycles while mem and mul are full. Response: am_wb_ready=0 until am is granted; no result is lost or duplicated.
REQ-036 Store (writereg=0) and a write to r0. Response: wb_reg_write=0 and wb_sb_clear=0 for both; cu_retired increments by 2.
REQ-037 Reset driven low while 2 slots are full. Response: outputs go 0 immediately; after release no write occurs and cu_busy=0.
REQ-038 Preset cu_retired to 0xFFFF, then retire one result. Response: cu_retired=0x0000.

Source files
------------

// File: rtl/completion_unit.sv
// completion_unit: writeback arbiter for three execution units.
//
// Each unit (am=0, mem=1, mul=2) owns a one-entry result slot. One full slot is
// granted per cycle in round-robin order starting after the last grant. The
// grant edge loads the registered writeback outputs and retires the slot.
//
// Ports:
//   clock, reset                 clock; asynchronous active-low reset
//   <u>_wb_valid/regdest/data/writereg   result presented by unit <u>
//   <u>_wb_ready                 slot of unit <u> can accept this cycle
//   wb_reg_addr/data/write       register file write port (registered)
//   wb_sb_addr/wb_sb_clear       scoreboard clear port, mirrors the write port
//   cu_busy                      at least one slot occupied
//   cu_retired                   wrapping count of retired results
module completion_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              am_wb_valid,
   input  logic [ADDR_W-1:0] am_wb_regdest,
   input  logic [DATA_W-1:0] am_wb_data,
   input  logic              am_wb_writereg,
   output logic              am_wb_ready,
   input  logic              mem_wb_valid,
   input  logic [ADDR_W-1:0] mem_wb_regdest,
   input  logic [DATA_W-1:0] mem_wb_data,
   input  logic              mem_wb_writereg,
   output logic              mem_wb_ready,
   input  logic              mul_wb_valid,
   input  logic [ADDR_W-1:0] mul_wb_regdest,
   input  logic [DATA_W-1:0] mul_wb_data,
   input  logic              mul_wb_writereg,
   output logic              mul_wb_ready,
   output logic [ADDR_W-1:0] wb_reg_addr,
   output logic [DATA_W-1:0] wb_reg_data,
   output logic              wb_reg_write,
   output logic [ADDR_W-1:0] wb_sb_addr,
   output logic              wb_sb_clear,
   output logic              cu_busy,
   output logic [15:0]       cu_retired
);

   localparam int unsigned NUM_SLOTS = 3;

   logic [2:0]        in_valid;
   logic [2:0]        in_writereg;
   logic [ADDR_W-1:0] in_regdest [NUM_SLOTS];
   logic [DATA_W-1:0] in_data    [NUM_SLOTS];

   assign in_valid       = {mul_wb_valid, mem_wb_valid, am_wb_valid};
   assign in_writereg    = {mul_wb_writereg, mem_wb_writereg, am_wb_writereg};
   assign in_regdest[0]  = am_wb_regdest;
   assign in_regdest[1]  = mem_wb_regdest;
   assign in_regdest[2]  = mul_wb_regdest;
   assign in_data[0]     = am_wb_data;
   assign in_data[1]     = mem_wb_data;
   assign in_data[2]     = mul_wb_data;

   logic [2:0]        full_q;
   logic [2:0]        writereg_q;
   logic [ADDR_W-1:0] regdest_q [NUM_SLOTS];
   logic [DATA_W-1:0] data_q    [NUM_SLOTS];
   logic [1:0]        last_grant_q;

   logic [1:0]        grant_idx;
   logic              grant_any;
   logic [2:0]        grant;
   logic [2:0]        ready;
   logic [2:0]        accept;
   logic [ADDR_W-1:0] sel_regdest;
   logic [DATA_W-1:0] sel_data;
   logic              sel_writereg;

   // Round-robin pick: search starts at the slot after the last grant.
   always_comb begin
      grant_idx = 2'd0;
      grant_any = |full_q;
      case (last_grant_q)
         2'd0: begin
            if (full_q[1])      grant_idx = 2'd1;
            else if (full_q[2]) grant_idx = 2'd2;
            else                grant_idx = 2'd0;
         end
         2'd1: begin
            if (full_q[2])      grant_idx = 2'd2;
            else if (full_q[0]) grant_idx = 2'd0;
            else                grant_idx = 2'd1;
         end
         default: begin
            if (full_q[0])      grant_idx = 2'd0;
            else if (full_q[1]) grant_idx = 2'd1;
            else                grant_idx = 2'd2;
         end
      endcase
   end

   always_comb begin
      sel_regdest  = regdest_q[0];
      sel_data     = data_q[0];
      sel_writereg = writereg_q[0];
      case (grant_idx)
         2'd1: begin
            sel_regdest  = regdest_q[1];
            sel_data     = data_q[1];
            sel_writereg = writereg_q[1];
         end
         2'd2: begin
            sel_regdest  = regdest_q[2];
            sel_data     = data_q[2];
            sel_writereg = writereg_q[2];
         end
         default: ;
      endcase
   end

   // Ready depends only on slot state and grant, so it never loops back through valid.
   assign grant  = grant_any ? (3'b001 << grant_idx) : 3'b000;
   assign ready  = ~full_q | grant;
   assign accept = in_valid & ready;

   assign am_wb_ready  = ready[0];
   assign mem_wb_ready = ready[1];
   assign mul_wb_ready = ready[2];
   assign cu_busy      = |full_q;
   assign wb_sb_addr   = wb_reg_addr;

   // Accept wins over the grant clear so a same-cycle refill keeps the slot full.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full_q     <= '0;
         writereg_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            regdest_q[i] <= '0;
            data_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (accept[i]) begin
               full_q[i]     <= 1'b1;
               writereg_q[i] <= in_writereg[i];
               regdest_q[i]  <= in_regdest[i];
               data_q[i]     <= in_data[i];
            end else if (grant[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant_q <= 2'd2;
         wb_reg_addr  <= '0;
         wb_reg_data  <= '0;
         wb_reg_write <= 1'b0;
         wb_sb_clear  <= 1'b0;
         cu_retired   <= '0;
      end else if (grant_any) begin
         last_grant_q <= grant_idx;
         wb_reg_addr  <= sel_regdest;
         wb_reg_data  <= sel_data;
         // Stores and r0 results retire silently.
         wb_reg_write <= sel_writereg && (sel_regdest != '0);
         wb_sb_clear  <= sel_writereg && (sel_regdest != '0);
         cu_retired   <= cu_retired + 16'd1;
      end else begin
         wb_reg_write <= 1'b0;
         wb_sb_clear  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_completion_unit.sv
module tb_completion_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_v [3];
   logic [4:0]  in_rd [3];
   logic [31:0] in_d [3];
   logic        in_w [3];

   logic        am_wb_ready, mem_wb_ready, mul_wb_ready;
   logic [4:0]  wb_reg_addr, wb_sb_addr;
   logic [31:0] wb_reg_data;
   logic        wb_reg_write, wb_sb_clear, cu_busy;
   logic [15:0] cu_retired;

   completion_unit #(.DATA_W(32), .ADDR_W(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .am_wb_valid    (in_v[0]),
      .am_wb_regdest  (in_rd[0]),
      .am_wb_data     (in_d[0]),
      .am_wb_writereg (in_w[0]),
      .am_wb_ready    (am_wb_ready),
      .mem_wb_valid   (in_v[1]),
      .mem_wb_regdest (in_rd[1]),
      .mem_wb_data    (in_d[1]),
      .mem_wb_writereg(in_w[1]),
      .mem_wb_ready   (mem_wb_ready),
      .mul_wb_valid   (in_v[2]),
      .mul_wb_regdest (in_rd[2]),
      .mul_wb_data    (in_d[2]),
      .mul_wb_writereg(in_w[2]),
      .mul_wb_ready   (mul_wb_ready),
      .wb_reg_addr    (wb_reg_addr),
      .wb_reg_data    (wb_reg_data),
      .wb_reg_write   (wb_reg_write),
      .wb_sb_addr     (wb_sb_addr),
      .wb_sb_clear    (wb_sb_clear),
      .cu_busy        (cu_busy),
      .cu_retired     (cu_retired)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: one entry per unit, a rotating priority pointer, and
   // the expected contents of the writeback port.
   bit          m_full [3];
   int          m_rd [3];
   logic [31:0] m_d [3];
   bit          m_w [3];
   int          m_lg;
   int          m_addr;
   logic [31:0] m_data;
   bit          m_write;
   int          m_ret;

   int          log_addr [$];
   logic [31:0] log_data [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_full[i] = 0;
      m_lg = 2; m_addr = 0; m_data = 0; m_write = 0; m_ret = 0;
   endtask

   function automatic int model_grant();
      for (int k = 1; k <= 3; k++) begin
         int idx = (m_lg + k) % 3;
         if (m_full[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_step();
      int g = model_grant();
      bit rdy [3];
      for (int i = 0; i < 3; i++) rdy[i] = !m_full[i] || (g == i);
      if (g >= 0) begin
         m_addr  = m_rd[g];
         m_data  = m_d[g];
         m_write = m_w[g] && (m_rd[g] != 0);
         m_ret   = (m_ret + 1) % 65536;
         m_lg    = g;
         m_full[g] = 0;
      end else begin
         m_write = 0;
      end
      for (int i = 0; i < 3; i++) begin
         if (in_v[i] && rdy[i]) begin
            m_full[i] = 1; m_rd[i] = in_rd[i]; m_d[i] = in_d[i]; m_w[i] = in_w[i];
         end
      end
   endtask

   task automatic compare_all();
      int g = model_grant();
      check("wb_reg_write", wb_reg_write, m_write);
      check("wb_sb_clear", wb_sb_clear, m_write);
      check("wb_reg_addr", wb_reg_addr, m_addr);
      check("wb_sb_addr", wb_sb_addr, m_addr);
      check("wb_reg_data", wb_reg_data, m_data);
      check("cu_retired", cu_retired, m_ret);
      check("cu_busy", cu_busy, m_full[0] || m_full[1] || m_full[2]);
      check("am_wb_ready", am_wb_ready, !m_full[0] || g == 0);
      check("mem_wb_ready", mem_wb_ready, !m_full[1] || g == 1);
      check("mul_wb_ready", mul_wb_ready, !m_full[2] || g == 2);
      if (wb_reg_write) begin
         log_addr.push_back(int'(wb_reg_addr));
         log_data.push_back(wb_reg_data);
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      compare_all();
      model_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         in_v[i] = 0; in_rd[i] = '0; in_d[i] = '0; in_w[i] = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic drive(input int u, input logic [4:0] rd, input logic [31:0] d, input bit w);
      in_v[u] = 1; in_rd[u] = rd; in_d[u] = d; in_w[u] = w;
   endtask

   typedef struct {
      int          unit;
      logic [4:0]  rd;
      logic [31:0] d;
      bit          w;
      bit          exp_write;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int cnt;
      int idx;
      bit saw_stall;
      logic [31:0] am_vals [3];
      logic [15:0] ret0;

      vecs[0] = '{2, 5'd7,  32'hDEADBEEF, 1'b1, 1'b1, 5'd7,  32'hDEADBEEF};
      vecs[1] = '{0, 5'd31, 32'h12345678, 1'b1, 1'b1, 5'd31, 32'h12345678};
      vecs[2] = '{1, 5'd4,  32'hCAFEF00D, 1'b0, 1'b0, 5'd4,  32'hCAFEF00D};
      vecs[3] = '{0, 5'd0,  32'h5555AAAA, 1'b1, 1'b0, 5'd0,  32'h5555AAAA};
      vecs[4] = '{1, 5'd12, 32'h00000000, 1'b1, 1'b1, 5'd12, 32'h00000000};

      idle_inputs();
      model_reset();
      #12;
      // Values held during reset.
      check("rst_write", wb_reg_write, 0);
      check("rst_clear", wb_sb_clear, 0);
      check("rst_addr", wb_reg_addr, 0);
      check("rst_data", wb_reg_data, 0);
      check("rst_retired", cu_retired, 0);
      check("rst_busy", cu_busy, 0);
      check("rst_ready", {am_wb_ready, mem_wb_ready, mul_wb_ready}, 3'b111);
      do_reset();

      // Single results through an idle unit, including a store and an r0 write.
      for (int t = 0; t < 5; t++) begin
         ret0 = cu_retired;
         drive(vecs[t].unit, vecs[t].rd, vecs[t].d, vecs[t].w);
         step();
         idle_inputs();
         check("vec_not_early", wb_reg_write, 0);
         step();
         check("vec_write", wb_reg_write, vecs[t].exp_write);
         check("vec_clear", wb_sb_clear, vecs[t].exp_write);
         check("vec_addr", wb_reg_addr, vecs[t].exp_addr);
         check("vec_data", wb_reg_data, vecs[t].exp_data);
         check("vec_retired", cu_retired, ret0 + 16'd1);
         step();
         check("vec_one_cycle", wb_reg_write, 0);
      end

      // All three at once, then am and mem together after mul was last granted.
      do_reset();
      drive(0, 5'd1, 32'h11, 1); drive(1, 5'd2, 32'h22, 1); drive(2, 5'd3, 32'h33, 1);
      step();
      idle_inputs();
      for (int c = 0; c < 4; c++) step();
      drive(0, 5'd8, 32'h88, 1); drive(1, 5'd9, 32'h99, 1);
      step();
      idle_inputs();
      for (int c = 0; c < 4; c++) step();
      check("rr_count", log_addr.size(), 5);
      if (log_addr.size() == 5) begin
         check("rr_w0", log_addr[0], 1);
         check("rr_w1", log_addr[1], 2);
         check("rr_w2", log_addr[2], 3);
         check("rr_am_first", log_addr[3], 8);
         check("rr_mem_next", log_addr[4], 9);
      end

      // am holds each result until ready while mem and mul are busy.
      do_reset();
      drive(1, 5'd10, 32'hA0000001, 1); drive(2, 5'd11, 32'hA0000002, 1);
      step();
      idle_inputs();
      am_vals[0] = 32'hB0000001; am_vals[1] = 32'hB0000002; am_vals[2] = 32'hB0000003;
      idx = 0;
      saw_stall = 0;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         bit rdy_now;
         drive(0, 5'd9, am_vals[idx], 1);
         rdy_now = am_wb_ready;
         if (!rdy_now) saw_stall = 1;
         step();
         if (rdy_now) idx++;
      end
      idle_inputs();
      for (int c = 0; c < 6; c++) step();
      check("hold_all_sent", idx, 3);
      check("hold_stalled", saw_stall, 1);
      for (int k = 0; k < 5; k++) begin
         logic [31:0] want;
         want = (k < 3) ? am_vals[k] : ((k == 3) ? 32'hA0000001 : 32'hA0000002);
         cnt = 0;
         foreach (log_data[j]) if (log_data[j] == want) cnt++;
         check("hold_once", cnt, 1);
      end

      // Asynchronous reset with two slots full.
      do_reset();
      drive(2, 5'd5, 32'h77, 1);
      step();
      idle_inputs();
      step();
      drive(0, 5'd6, 32'h66, 1); drive(1, 5'd13, 32'h55, 1);
      step();
      idle_inputs();
      check("pre_rst_busy", cu_busy, 1);
      #2 reset = 1'b0;
      #1;
      check("arst_write", wb_reg_write, 0);
      check("arst_clear", wb_sb_clear, 0);
      check("arst_addr", wb_reg_addr, 0);
      check("arst_data", wb_reg_data, 0);
      check("arst_retired", cu_retired, 0);
      check("arst_busy", cu_busy, 0);
      check("arst_ready", {am_wb_ready, mem_wb_ready, mul_wb_ready}, 3'b111);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      log_addr.delete();
      log_data.delete();
      for (int c = 0; c < 4; c++) step();
      check("arst_no_write", log_addr.size(), 0);
      check("arst_idle", cu_busy, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int u = 0; u < 3; u++) begin
            in_v[u]  = ($urandom_range(0, 9) < 6);
            in_rd[u] = 5'($urandom_range(0, 31));
            in_d[u]  = $urandom;
            in_w[u]  = ($urandom_range(0, 4) != 0);
         end
         step();
      end
      idle_inputs();
      for (int c = 0; c < 4; c++) step();

      // Retire counter wrap.
      do_reset();
      drive(0, 5'd1, 32'h1, 1);
      cnt = 0;
      while (m_ret != 65535 && cnt < 70000) begin
         model_step();
         @(posedge clock);
         @(negedge clock);
         cnt++;
      end
      check("wrap_reach", cu_retired, 16'hFFFF);
      idle_inputs();
      step();
      check("wrap_zero", cu_retired, 16'h0000);
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
